// File: rtl/gb_video_pkg.sv
// Shared Game Boy video definitions.
// - GB_SCREEN_WIDTH / GB_SCREEN_HEIGHT: native LCD size, used as default source dimensions.
// - GB_GRAY_*: 8-bit grayscale levels for the four 2-bit palette indices (lightest first).
// - gb_gray(): maps a 2-bit index onto its grayscale level.
// - buf_addr_width(): address bits needed to hold one w x h frame.
package gb_video_pkg;

    localparam int unsigned GB_SCREEN_WIDTH  = 160;
    localparam int unsigned GB_SCREEN_HEIGHT = 144;

    localparam logic [7:0] GB_GRAY_0 = 8'hFF;
    localparam logic [7:0] GB_GRAY_1 = 8'hAA;
    localparam logic [7:0] GB_GRAY_2 = 8'h55;
    localparam logic [7:0] GB_GRAY_3 = 8'h00;

    function automatic logic [7:0] gb_gray(input logic [1:0] idx);
        logic [7:0] level;
        case (idx)
            2'd0:    level = GB_GRAY_0;
            2'd1:    level = GB_GRAY_1;
            2'd2:    level = GB_GRAY_2;
            default: level = GB_GRAY_3;
        endcase
        return level;
    endfunction

    function automatic int unsigned buf_addr_width(input int unsigned w, input int unsigned h);
        return $clog2(w * h);
    endfunction

endpackage

// File: rtl/gb_frame_ram.sv
// Single-clock simple dual-port RAM: one write port, one registered read port.
// Read-during-write to the same address returns the old contents; the scaler never does this
// because the write and read sides always address different instances.
// Ports:
//   clk_i            clock
//   we_i             write enable
//   waddr_i/wdata_i  write address / data
//   raddr_i          read address, sampled every cycle
//   rdata_o          read data, one cycle after raddr_i
module gb_frame_ram #(
    parameter int unsigned AddrW = 15,
    parameter int unsigned DataW = 2
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [DataW-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [DataW-1:0] rdata_o
);

    logic [DataW-1:0] mem [2**AddrW];
    logic [DataW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/gb_frame_scaler.sv
// Game Boy frame scaler: captures the LCD pixel stream into a back buffer and reads the front
// buffer back as an integer-scaled window inside a host display raster. Buffers swap only at a
// display frame start, so a displayed frame is never torn.
//
// Optional feature: define GB_FRAME_SCALER_PALETTE_EN to add a writable palette
// (ports pal_we, pal_idx, pal_rgb); otherwise a fixed grayscale palette is used.
//
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   pixel_data, data_latch       source pixel and its strobe (written on the strobe's rise)
//   gb_hsync, gb_vsync           source line / frame syncs
//   vga_pix_en, vga_x, vga_y     display pixel strobe and coordinates
//   vga_frame_start              display frame boundary strobe (swap point)
//   vga_rgb, vga_valid           output pixel, two cycles after vga_pix_en
//   frame_dropped                pulse: a ready frame was overwritten before being shown
//   wr_overflow                  sticky: a write outside the source frame was suppressed
//   pal_we, pal_idx, pal_rgb     palette write port (GB_FRAME_SCALER_PALETTE_EN only)
module gb_frame_scaler
    import gb_video_pkg::*;
#(
    parameter int unsigned SRC_WIDTH  = GB_SCREEN_WIDTH,
    parameter int unsigned SRC_HEIGHT = GB_SCREEN_HEIGHT,
    parameter int unsigned PIX_BITS   = 2,
    parameter int unsigned SCALE_LOG2 = 1,
    parameter int unsigned X_OFFSET   = 160,
    parameter int unsigned Y_OFFSET   = 76,
    parameter int unsigned COLOR_BITS = 8,
    parameter int unsigned ADDR_W     = buf_addr_width(GB_SCREEN_WIDTH, GB_SCREEN_HEIGHT)
) (
    input  logic                    clock,
    input  logic                    reset,
`ifdef GB_FRAME_SCALER_PALETTE_EN
    input  logic                    pal_we,
    input  logic [PIX_BITS-1:0]     pal_idx,
    input  logic [3*COLOR_BITS-1:0] pal_rgb,
`endif
    input  logic [PIX_BITS-1:0]     pixel_data,
    input  logic                    gb_hsync,
    input  logic                    gb_vsync,
    input  logic                    data_latch,
    input  logic                    vga_pix_en,
    input  logic                    vga_frame_start,
    input  logic [9:0]              vga_x,
    input  logic [9:0]              vga_y,
    output logic [3*COLOR_BITS-1:0] vga_rgb,
    output logic                    vga_valid,
    output logic                    frame_dropped,
    output logic                    wr_overflow
);

    localparam int unsigned PIX_CNT_W  = $clog2(SRC_WIDTH + 1);
    localparam int unsigned LINE_CNT_W = $clog2(SRC_HEIGHT + 1);
    localparam logic [PIX_CNT_W-1:0]  PIX_MAX  = PIX_CNT_W'(SRC_WIDTH);
    localparam logic [LINE_CNT_W-1:0] LINE_MAX = LINE_CNT_W'(SRC_HEIGHT);
    localparam int unsigned WIN_W = SRC_WIDTH << SCALE_LOG2;
    localparam int unsigned WIN_H = SRC_HEIGHT << SCALE_LOG2;

    // Grayscale level for an index: fixed table for 2-bit pixels, otherwise the inverted
    // index MSB-aligned. Either way the value is MSB-aligned into COLOR_BITS.
    function automatic logic [COLOR_BITS-1:0] gray_level(input logic [PIX_BITS-1:0] idx);
        logic [31:0] aligned;
        if (PIX_BITS == 2) begin
            aligned = {gb_gray(2'(idx)), 24'd0};
        end else begin
            aligned = {~idx, {(32 - PIX_BITS){1'b0}}};
        end
        return COLOR_BITS'(aligned >> (32 - COLOR_BITS));
    endfunction

    // ---------------------------------------------------------------- write side
    logic                  hsync_q, vsync_q, latch_q;
    logic                  front_sel_q, front_sel_d;
    logic                  ready_q, ready_d;
    logic [PIX_CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic                  frame_dropped_q, frame_dropped_d;
    logic                  wr_overflow_q, wr_overflow_d;

    logic              latch_rise, latch_fall, hsync_fall, vsync_rise, swap;
    logic              wr_in_range, wr_en;
    logic [ADDR_W-1:0] wr_addr;

    assign latch_rise = data_latch & ~latch_q;
    assign latch_fall = ~data_latch & latch_q;
    assign hsync_fall = ~gb_hsync & hsync_q;
    assign vsync_rise = gb_vsync & ~vsync_q;
    assign swap       = vga_frame_start & ready_q;

    assign wr_in_range = (pix_cnt_q < PIX_MAX) && (line_cnt_q < LINE_MAX);
    assign wr_en       = latch_rise & wr_in_range;
    assign wr_addr     = ADDR_W'(32'(line_cnt_q) * SRC_WIDTH + 32'(pix_cnt_q));

    always_comb begin
        pix_cnt_d       = pix_cnt_q;
        line_cnt_d      = line_cnt_q;
        wr_overflow_d   = wr_overflow_q;
        front_sel_d     = front_sel_q ^ swap;
        ready_d         = ready_q;
        frame_dropped_d = 1'b0;

        if (latch_rise && !wr_in_range) begin
            wr_overflow_d = 1'b1;
        end
        if (latch_fall && (pix_cnt_q != PIX_MAX)) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
        end
        if (hsync_fall) begin
            pix_cnt_d = '0;
            if (line_cnt_q != LINE_MAX) begin
                line_cnt_d = line_cnt_q + 1'b1;
            end
        end

        if (swap) begin
            ready_d = 1'b0;
        end
        // Vsync is evaluated after the swap so a coincident swap consumes the old frame and
        // the new one is marked ready without a drop. The write above already used the
        // pre-clear address.
        if (vsync_rise) begin
            pix_cnt_d       = '0;
            line_cnt_d      = '0;
            wr_overflow_d   = 1'b0;
            ready_d         = 1'b1;
            frame_dropped_d = ready_q & ~swap;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hsync_q         <= 1'b0;
            vsync_q         <= 1'b0;
            latch_q         <= 1'b0;
            front_sel_q     <= 1'b0;
            ready_q         <= 1'b0;
            pix_cnt_q       <= '0;
            line_cnt_q      <= '0;
            frame_dropped_q <= 1'b0;
            wr_overflow_q   <= 1'b0;
        end else begin
            hsync_q         <= gb_hsync;
            vsync_q         <= gb_vsync;
            latch_q         <= data_latch;
            front_sel_q     <= front_sel_d;
            ready_q         <= ready_d;
            pix_cnt_q       <= pix_cnt_d;
            line_cnt_q      <= line_cnt_d;
            frame_dropped_q <= frame_dropped_d;
            wr_overflow_q   <= wr_overflow_d;
        end
    end

    assign frame_dropped = frame_dropped_q;
    assign wr_overflow   = wr_overflow_q;

    // ---------------------------------------------------------------- buffers
    // front_sel_q names the displayed buffer; the other one is written.
    logic [ADDR_W-1:0]   rd_addr;
    logic [PIX_BITS-1:0] ram0_rdata, ram1_rdata;
    logic                ram0_we, ram1_we;

    assign ram0_we = wr_en & front_sel_q;
    assign ram1_we = wr_en & ~front_sel_q;

    gb_frame_ram #(
        .AddrW (ADDR_W),
        .DataW (PIX_BITS)
    ) u_ram0 (
        .clk_i   (clock),
        .we_i    (ram0_we),
        .waddr_i (wr_addr),
        .wdata_i (pixel_data),
        .raddr_i (rd_addr),
        .rdata_o (ram0_rdata)
    );

    gb_frame_ram #(
        .AddrW (ADDR_W),
        .DataW (PIX_BITS)
    ) u_ram1 (
        .clk_i   (clock),
        .we_i    (ram1_we),
        .waddr_i (wr_addr),
        .wdata_i (pixel_data),
        .raddr_i (rd_addr),
        .rdata_o (ram1_rdata)
    );

    // ---------------------------------------------------------------- read pipeline
    logic [31:0] dx_full, dy_full;
    logic [9:0]  dx, dy;
    logic        s0_in_win;

    // Subtracting first makes columns left of the window wrap to large values, so one
    // unsigned compare covers both window edges.
    assign dx_full   = {22'd0, vga_x} - X_OFFSET;
    assign dy_full   = {22'd0, vga_y} - Y_OFFSET;
    assign dx        = dx_full[9:0];
    assign dy        = dy_full[9:0];
    assign s0_in_win = vga_pix_en && (dx_full < WIN_W) && (dy_full < WIN_H);
    assign rd_addr   = ADDR_W'(32'(dy >> SCALE_LOG2) * SRC_WIDTH + 32'(dx >> SCALE_LOG2));

    logic                    s1_valid_q, s1_in_win_q, s1_sel_q;
    logic [PIX_BITS-1:0]     front_pix;
    logic [3*COLOR_BITS-1:0] pal_color;
    logic [3*COLOR_BITS-1:0] vga_rgb_q, vga_rgb_d;
    logic                    vga_valid_q;

`ifdef GB_FRAME_SCALER_PALETTE_EN
    localparam int unsigned PAL_N = 2**PIX_BITS;
    logic [3*COLOR_BITS-1:0] pal_q [PAL_N];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < PAL_N; i++) begin
                pal_q[i] <= {3{gray_level(PIX_BITS'(i))}};
            end
        end else if (pal_we) begin
            pal_q[pal_idx] <= pal_rgb;
        end
    end

    assign pal_color = pal_q[front_pix];
`else
    assign pal_color = {3{gray_level(front_pix)}};
`endif

    always_comb begin
        front_pix = s1_sel_q ? ram1_rdata : ram0_rdata;
        vga_rgb_d = s1_in_win_q ? pal_color : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_in_win_q <= 1'b0;
            s1_sel_q    <= 1'b0;
            vga_rgb_q   <= '0;
            vga_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= vga_pix_en;
            s1_in_win_q <= s0_in_win;
            s1_sel_q    <= front_sel_q;
            vga_rgb_q   <= vga_rgb_d;
            vga_valid_q <= s1_valid_q;
        end
    end

    assign vga_rgb   = vga_rgb_q;
    assign vga_valid = vga_valid_q;

endmodule

// File: tb/tb_gb_frame_scaler.sv
// Directed bench for gb_frame_scaler. Two instances share all inputs: dut_a uses the default
// geometry (scale 2, window at 160,76), dut_b uses scale 4 with the window at the origin.
module tb_gb_frame_scaler;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic [1:0]  pixel_data;
    logic        gb_hsync, gb_vsync, data_latch;
    logic        vga_pix_en, vga_frame_start;
    logic [9:0]  vga_x, vga_y;
    logic [23:0] rgb_a, rgb_b;
    logic        valid_a, valid_b, drop_a, drop_b, ovf_a, ovf_b;
`ifdef GB_FRAME_SCALER_PALETTE_EN
    logic        pal_we;
    logic [1:0]  pal_idx;
    logic [23:0] pal_rgb;
`endif

    gb_frame_scaler dut_a (
        .clock           (clock),
        .reset           (reset),
`ifdef GB_FRAME_SCALER_PALETTE_EN
        .pal_we          (pal_we),
        .pal_idx         (pal_idx),
        .pal_rgb         (pal_rgb),
`endif
        .pixel_data      (pixel_data),
        .gb_hsync        (gb_hsync),
        .gb_vsync        (gb_vsync),
        .data_latch      (data_latch),
        .vga_pix_en      (vga_pix_en),
        .vga_frame_start (vga_frame_start),
        .vga_x           (vga_x),
        .vga_y           (vga_y),
        .vga_rgb         (rgb_a),
        .vga_valid       (valid_a),
        .frame_dropped   (drop_a),
        .wr_overflow     (ovf_a)
    );

    gb_frame_scaler #(
        .SCALE_LOG2 (2),
        .X_OFFSET   (0),
        .Y_OFFSET   (0)
    ) dut_b (
        .clock           (clock),
        .reset           (reset),
`ifdef GB_FRAME_SCALER_PALETTE_EN
        .pal_we          (pal_we),
        .pal_idx         (pal_idx),
        .pal_rgb         (pal_rgb),
`endif
        .pixel_data      (pixel_data),
        .gb_hsync        (gb_hsync),
        .gb_vsync        (gb_vsync),
        .data_latch      (data_latch),
        .vga_pix_en      (vga_pix_en),
        .vga_frame_start (vga_frame_start),
        .vga_x           (vga_x),
        .vga_y           (vga_y),
        .vga_rgb         (rgb_b),
        .vga_valid       (valid_b),
        .frame_dropped   (drop_b),
        .wr_overflow     (ovf_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] exp_a;
        logic [23:0] exp_b;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Source image patterns: 0 gradient, 1/2 shifted gradients, 3 all 2s, 4 all 0s.
    function automatic logic [1:0] pat(input int kind, input int x, input int y);
        case (kind)
            0:       return 2'((x + y) % 4);
            1:       return 2'((x + y + 1) % 4);
            2:       return 2'((x + y + 2) % 4);
            3:       return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    task automatic latch_pixel(input logic [1:0] val);
        pixel_data = val;
        data_latch = 1'b1;
        tick();
        data_latch = 1'b0;
        tick();
    endtask

    task automatic hsync_pulse();
        gb_hsync = 1'b1;
        tick();
        gb_hsync = 1'b0;
        tick();
    endtask

    task automatic write_line(input int y, input int kind);
        for (int x = 0; x < 160; x++) begin
            latch_pixel(pat(kind, x, y));
        end
        hsync_pulse();
    endtask

    task automatic vsync_pulse(input logic exp_drop, input string name);
        gb_vsync = 1'b1;
        tick();
        check({name, "_drop_pulse"}, 32'(drop_a), 32'(exp_drop));
        gb_vsync = 1'b0;
        tick();
        check({name, "_drop_after"}, 32'(drop_a), 32'd0);
    endtask

    task automatic frame_start();
        vga_frame_start = 1'b1;
        tick();
        vga_frame_start = 1'b0;
        tick();
    endtask

    task automatic read_pix(input string name, input int x, input int y,
                            input logic [23:0] exp_a, input logic [23:0] exp_b,
                            input logic chk_b);
        vga_x      = 10'(x);
        vga_y      = 10'(y);
        vga_pix_en = 1'b1;
        tick();
        vga_pix_en = 1'b0;
        check({name, "_valid_early"}, 32'(valid_a), 32'd0);
        tick();
        check({name, "_valid"}, 32'(valid_a), 32'd1);
        check({name, "_rgb_a"}, 32'(rgb_a), 32'(exp_a));
        if (chk_b) begin
            check({name, "_rgb_b"}, 32'(rgb_b), 32'(exp_b));
        end
    endtask

    initial begin
        // Gradient frame expectations: dut_a maps (160+2x, 76+2y) to source (x,y);
        // dut_b maps (4x.., 4y..) to source (x,y).
        vecs[0]  = '{x: 10'd160, y: 10'd76,  exp_a: 24'hFFFFFF, exp_b: 24'h000000};
        vecs[1]  = '{x: 10'd161, y: 10'd77,  exp_a: 24'hFFFFFF, exp_b: 24'h000000};
        vecs[2]  = '{x: 10'd162, y: 10'd76,  exp_a: 24'hAAAAAA, exp_b: 24'h000000};
        vecs[3]  = '{x: 10'd164, y: 10'd78,  exp_a: 24'h000000, exp_b: 24'hFFFFFF};
        vecs[4]  = '{x: 10'd479, y: 10'd363, exp_a: 24'h555555, exp_b: 24'hAAAAAA};
        vecs[5]  = '{x: 10'd480, y: 10'd100, exp_a: 24'h000000, exp_b: 24'hAAAAAA};
        vecs[6]  = '{x: 10'd159, y: 10'd100, exp_a: 24'h000000, exp_b: 24'hFFFFFF};
        vecs[7]  = '{x: 10'd300, y: 10'd75,  exp_a: 24'h000000, exp_b: 24'hAAAAAA};
        vecs[8]  = '{x: 10'd300, y: 10'd364, exp_a: 24'h000000, exp_b: 24'h555555};
        vecs[9]  = '{x: 10'd0,   y: 10'd0,   exp_a: 24'h000000, exp_b: 24'hFFFFFF};
        vecs[10] = '{x: 10'd3,   y: 10'd3,   exp_a: 24'h000000, exp_b: 24'hFFFFFF};
        vecs[11] = '{x: 10'd4,   y: 10'd0,   exp_a: 24'h000000, exp_b: 24'hAAAAAA};
        vecs[12] = '{x: 10'd2,   y: 10'd1,   exp_a: 24'h000000, exp_b: 24'hFFFFFF};
        vecs[13] = '{x: 10'd639, y: 10'd575, exp_a: 24'h000000, exp_b: 24'h555555};
        vecs[14] = '{x: 10'd640, y: 10'd0,   exp_a: 24'h000000, exp_b: 24'h000000};
        vecs[15] = '{x: 10'd200, y: 10'd150, exp_a: 24'hAAAAAA, exp_b: 24'h000000};
        vecs[16] = '{x: 10'd321, y: 10'd219, exp_a: 24'h000000, exp_b: 24'h555555};

        reset           = 1'b1;
        pixel_data      = 2'd0;
        gb_hsync        = 1'b0;
        gb_vsync        = 1'b0;
        data_latch      = 1'b0;
        vga_pix_en      = 1'b0;
        vga_frame_start = 1'b0;
        vga_x           = 10'd0;
        vga_y           = 10'd0;
`ifdef GB_FRAME_SCALER_PALETTE_EN
        pal_we          = 1'b0;
        pal_idx         = 2'd0;
        pal_rgb         = 24'd0;
`endif
        repeat (3) tick();
        check("reset_rgb", 32'(rgb_a), 32'd0);
        check("reset_valid", 32'(valid_a), 32'd0);
        check("reset_drop", 32'(drop_a), 32'd0);
        check("reset_ovf", 32'(ovf_a), 32'd0);
        reset = 1'b0;
        tick();

        // Full gradient frame, then show it.
        for (int y = 0; y < 144; y++) begin
            write_line(y, 0);
        end
        check("full_frame_ovf", 32'(ovf_a), 32'd0);
        vsync_pulse(1'b0, "vs_a");
        frame_start();
        for (int i = 0; i < NVEC; i++) begin
            read_pix($sformatf("vec%0d", i), int'(vecs[i].x), int'(vecs[i].y),
                     vecs[i].exp_a, vecs[i].exp_b, 1'b1);
        end

        // Two source frames without a display frame start: second one drops the first.
        write_line(0, 1);
        write_line(1, 1);
        vsync_pulse(1'b0, "vs_f2");
        write_line(0, 2);
        write_line(1, 2);
        vsync_pulse(1'b1, "vs_f3");
        frame_start();
        read_pix("drop_show0", 160, 76, 24'h555555, 24'h0, 1'b0);
        read_pix("drop_show1", 162, 78, 24'hFFFFFF, 24'h0, 1'b0);
        read_pix("drop_show_b", 4, 4, 24'h000000, 24'hFFFFFF, 1'b1);

        // 161 latches on one line: the last write is suppressed and flags overflow.
        for (int x = 0; x < 160; x++) begin
            latch_pixel(pat(3, x, 0));
        end
        check("ovf_before", 32'(ovf_a), 32'd0);
        latch_pixel(2'd3);
        check("ovf_set", 32'(ovf_a), 32'd1);
        hsync_pulse();
        check("ovf_sticky", 32'(ovf_a), 32'd1);
        vsync_pulse(1'b0, "vs_ovf");
        check("ovf_cleared", 32'(ovf_a), 32'd0);
        frame_start();
        read_pix("ovf_line0", 170, 76, 24'h555555, 24'hAAAAAA, 1'b1);
        // Source (0,1) must still hold the gradient value, not the suppressed 3.
        read_pix("ovf_next_line", 160, 78, 24'hAAAAAA, 24'h000000, 1'b1);

        // Frame start coincident with vsync rise while ready: swap, stay ready, no drop.
        write_line(0, 4);
        vsync_pulse(1'b0, "vs_f6");
        gb_vsync        = 1'b1;
        vga_frame_start = 1'b1;
        tick();
        check("coinc_drop_pulse", 32'(drop_a), 32'd0);
        gb_vsync        = 1'b0;
        vga_frame_start = 1'b0;
        tick();
        check("coinc_drop_after", 32'(drop_a), 32'd0);
        read_pix("coinc_show", 170, 76, 24'hFFFFFF, 24'h0, 1'b0);
        frame_start();
        read_pix("coinc_ready", 170, 76, 24'h555555, 24'hAAAAAA, 1'b1);

`ifdef GB_FRAME_SCALER_PALETTE_EN
        pal_we  = 1'b1;
        pal_idx = 2'd1;
        pal_rgb = 24'hFF0000;
        tick();
        pal_we  = 1'b0;
        read_pix("pal_idx1", 160, 78, 24'hFF0000, 24'h000000, 1'b1);
        read_pix("pal_idx2", 170, 76, 24'h555555, 24'h0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gb_frame_scaler.md
Name: gb_frame_scaler

Overview:
- Single-clock successor to the Game Boy video capture path.
- Captures the Game Boy LCD pixel stream into one of two frame buffers and reads the other back as an integer-scaled, offset window inside a host display raster.
- Buffer swap is deferred to the display frame boundary (tear-free). Source size, pixel depth, scale and offsets are parametrised.
- Sits between the gb core LCD outputs and the display timing generator; both run on `clock`, and the display side qualifies pixels with a strobe.

Parameters:
- SRC_WIDTH, 160, source pixels per line
- SRC_HEIGHT, 144, source lines per frame
- PIX_BITS, 2, bits per source pixel (palette index)
- SCALE_LOG2, 1, output scale factor = 2**SCALE_LOG2 (1,2,4,8 allowed)
- X_OFFSET, 160, first display column of the window
- Y_OFFSET, 76, first display line of the window
- COLOR_BITS, 8, bits per RGB channel
- ADDR_W, 15, buffer address width; must satisfy 2**ADDR_W >= SRC_WIDTH*SRC_HEIGHT

Ports:
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- pixel_data  in  PIX_BITS  source pixel value
- gb_hsync  in  1  source line sync, active high
- gb_vsync  in  1  source frame sync, active high
- data_latch  in  1  source pixel strobe, active high
- vga_pix_en  in  1  one-cycle strobe per display pixel
- vga_frame_start  in  1  one-cycle strobe at display frame start
- vga_x  in  10  display column for this strobe
- vga_y  in  10  display line for this strobe
- vga_rgb  out  3*COLOR_BITS  {R,G,B} output pixel
- vga_valid  out  1  vga_rgb valid this cycle
- frame_dropped  out  1  one-cycle pulse: source frame overwrote an unshown frame
- wr_overflow  out  1  sticky: write beyond SRC_WIDTH*SRC_HEIGHT suppressed

Behaviour:
Reset (synchronous, active-high):
- front_sel=0, ready=0, all counters 0, edge registers 0.
- vga_rgb=0, vga_valid=0, frame_dropped=0, wr_overflow=0.
- Reset asserted mid-frame abandons the frame; the front buffer contents are undefined until the first swap.

Write side:
- Edge detect each sync and strobe against its value registered the previous cycle.
- Rising edge of data_latch: write pixel_data to the back buffer at line_cnt*SRC_WIDTH + pix_cnt.
- If line_cnt >= SRC_HEIGHT or pix_cnt >= SRC_WIDTH, suppress the write and set wr_overflow.
- Falling edge of data_latch: pix_cnt+1, saturating at SRC_WIDTH.
- Falling edge of gb_hsync: line_cnt+1, saturating at SRC_HEIGHT, and pix_cnt=0.
- Rising edge of gb_vsync:
  - line_cnt=0, pix_cnt=0, wr_overflow cleared;
  - if ready=1 already, pulse frame_dropped for 1 cycle; ready stays 1 and the back buffer is rewritten;
  - otherwise ready=1.
- Simultaneous latch-rise and vsync-rise: the write uses the pre-clear address; the counters then clear.

Swap:
- On vga_frame_start with ready=1: toggle front_sel and set ready=0.
- On vga_frame_start in the same cycle as a gb_vsync rise, the swap wins and ready is then set by the vsync, so no drop is reported.

Read pipeline (all pipeline stages advance every cycle, not only on vga_pix_en):
- S0 (vga_pix_en cycle): dx=vga_x-X_OFFSET, dy=vga_y-Y_OFFSET, both unsigned 10-bit.
- Window condition: vga_x in [X_OFFSET, X_OFFSET+SRC_WIDTH<<SCALE_LOG2) and vga_y in [Y_OFFSET, Y_OFFSET+SRC_HEIGHT<<SCALE_LOG2).
- Read address = (dy>>SCALE_LOG2)*SRC_WIDTH + (dx>>SCALE_LOG2), truncated to ADDR_W.
- S1: registered front-buffer read.
- S2: palette map. Out-of-window pixels output 0.
- Latency: vga_rgb and vga_valid are registered 2 clock cycles after the vga_pix_en cycle. vga_valid is vga_pix_en delayed by 2.
- Fixed palette for PIX_BITS=2: 0->FF, 1->AA, 2->55, 3->00, replicated on all channels.
- For PIX_BITS>2, the output is the inverted index MSB-aligned into COLOR_BITS.
- Read and write never target the same buffer in the same cycle.

Optional Feature:
- Macro: GB_FRAME_SCALER_PALETTE_EN.
- When defined:
  - adds ports pal_we (in 1), pal_idx (in PIX_BITS) and pal_rgb (in 3*COLOR_BITS);
  - 2**PIX_BITS palette registers are written synchronously on pal_we;
  - reset loads the fixed grayscale values;
  - a write takes effect on S2 outputs from the next cycle.
- When undefined: the fixed palette only, and the ports are absent.

Decomposition:
- Package gb_video_pkg:
  - GB_SCREEN_WIDTH/HEIGHT defaults;
  - grayscale palette constants;
  - a function returning the buffer address width for given dimensions.
- One sub-module, gb_frame_ram: single-clock simple dual-port RAM (1 write port, 1 registered read port), ADDR_W x PIX_BITS.
  - Two instances, with address and write-enable muxed by front_sel.

Test Plan:
- Reset then full 160x144 gradient frame (pixel=(x+y)%4), vga_frame_start, raster scan -> window pixel (X_OFFSET+2x, Y_OFFSET+2y) equals the palette of (x+y)%4, 2-cycle latency, outside window 0.
- Two gb_vsync rises with no vga_frame_start between them -> frame_dropped single-cycle pulse on the second; after the next frame_start the second frame is displayed.
- 161 latches in one line -> the 161st write is suppressed, wr_overflow=1; it clears on the next gb_vsync rise.
- vga_frame_start and gb_vsync rise in the same cycle with ready=1 -> swap occurs, ready=1 after, frame_dropped=0.
- SCALE_LOG2=2, X_OFFSET=0, Y_OFFSET=0 -> display pixels (0..3,0..3) all map to source (0,0); (4,0) maps to source (1,0).
- With GB_FRAME_SCALER_PALETTE_EN defined: write index 1 = 0xFF0000 -> source value 1 displays 0xFF0000 from the next cycle.
